dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data memory port (DataMem plus the GPIO write path) between two requesters: the core load/store path (port C) and an external host/debug loader (port H).
- Grants are registered, one owner at a time.
- Round-robin selection with a bounded burst length, plus a host lock for debug halts.
- Sits between the ALU/Store-block address/data outputs and the DataMem/GPIO_control inputs; raises a stall toward the PC when the core is not served.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MAX_BURST, 4, max consecutive acked beats for one owner while the other requester waits; range 1..15.
- CNT_W, 4, beat counter width; must satisfy 2^CNT_W > MAX_BURST.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- c_req  in  1  core access request; held with addr/we/wdata stable until c_ack.
- c_we  in  1  core write enable (MemW).
- c_addr  in  AW  core address.
- c_wdata  in  DW  core write data (Store_out).
- c_ack  out  1  core beat accepted this cycle.
- c_rdata  out  DW  core read data, valid when c_ack=1.
- c_stall  out  1  c_req & ~c_ack; freezes PC/RegWEn.
- h_req  in  1  host request; same hold rule as c_req.
- h_we  in  1  host write enable.
- h_addr  in  AW  host address.
- h_wdata  in  DW  host write data.
- h_lock  in  1  while the host owns the bus, suppresses the burst limit.
- h_ack  out  1  host beat accepted this cycle.
- h_rdata  out  DW  host read data, valid when h_ack=1.
- m_addr  out  AW  memory address.
- m_wdata  out  DW  memory write data.
- m_we  out  1  memory write strobe; the write commits at the clk edge ending the cycle.
- m_rdata  in  DW  memory combinational read data.
- owner  out  2  debug: 00 idle, 01 core, 10 host.

Behaviour:
- Reset and clocking: one clock; reset is synchronous and active-high. With rst=1 at an edge: state=IDLE, beat_cnt=0, last=H (so the core wins the first tie).
  - After that edge: owner=00; c_ack=h_ack=0; m_we=0; m_addr=m_wdata=0; c_rdata=h_rdata=0.
  - m_we is also forced 0 combinationally during any cycle with rst=1. A write in flight during reset is dropped.
- States: IDLE, GNT_C, GNT_H. owner is decoded from the state register.
- IDLE:
  - No acks. m_addr, m_wdata and m_we are driven 0.
  - Next state: only c_req -> GNT_C; only h_req -> GNT_H; both -> the requester not equal to last; none -> IDLE.
  - Arbitration latency from IDLE is 1 cycle: req seen at edge N, first ack during cycle N+1.
- GNT_x (owner x, other y):
  - Mux: m_addr/m_wdata/m_we = x's signals; m_we = x_we & x_req.
  - Ack: x_ack = x_req (combinational); y_ack=0.
  - Read data: x_rdata = m_rdata when x_ack, else 0; y_rdata=0.
  - Beat counter: each edge with x_ack=1 does beat_cnt++, saturating at MAX_BURST.
  - Transitions, evaluated in priority order:
    1. x_req=0 and y_req=1 -> GNT_y; beat_cnt=0; last=x.
    2. x_req=0 and y_req=0 -> IDLE; beat_cnt=0; last=x.
    3. y_req=1 and beat_cnt+x_ack >= MAX_BURST, and not (x=H and h_lock=1) -> GNT_y; beat_cnt=0; last=x.
    4. Otherwise stay in GNT_x.
  - Switching is direct (no IDLE bubble). The first ack for the new owner comes in the next cycle.
- Stall: c_stall is combinational. While the host holds the bus, the core stalls indefinitely if h_lock=1, otherwise for at most MAX_BURST cycles after the core's request is seen.
- Throughput: continuous single-owner requests give one beat per cycle.
- Writes and reads:
  - Back-to-back read-after-write to the same address by one owner returns the new data, because the write commits at the edge.
  - Write side effects occur only on acked cycles.
- Requester rules:
  - A requester dropping req without an ack is legal; it is treated as a withdrawal.
  - The block does not check stability of held signals; the bench asserts it.
- No address decode is done here. GPIO_control consumes m_we/m_addr downstream.

Decomposition:
- Shared package dmem_arb_pkg:
  - state encoding constants ST_IDLE=2'b00, ST_GNT_C=2'b01, ST_GNT_H=2'b10 (owner reuses this encoding);
  - requester ids REQ_C=1'b0, REQ_H=1'b1.
- One natural sub-module: arb_burst_counter, holding beat_cnt with clear, increment and saturation, and exporting limit_hit.

Test Plan:
- Reset, then only c_req=1, c_we=0, c_addr=0x10 -> owner=01 and c_ack=1 from the second cycle. c_rdata equals mem[0x10]; h_ack=0 throughout.
- c_req and h_req rise together from IDLE after reset -> core granted first. Core holds req for 6 beats with MAX_BURST=4 -> core acked exactly 4 cycles, then GNT_H immediately, h_ack=1 on the next cycle.
- Host owns the bus with h_lock=1 for 10 beats while c_req=1 -> c_stall=1 for all 10 cycles. Drop h_lock and h_req -> next cycle owner=01, c_ack=1.
- Host writes 0xDEADBEEF to 0x20, then reads 0x20 on the next beat -> h_rdata=0xDEADBEEF. m_we was high only in the write beat.
- Assert rst mid-burst in GNT_C with c_we=1 -> m_we=0 in the reset cycle and memory unchanged. Next cycle owner=00 with no acks.
- Core drops c_req in GNT_C while h_req=0 -> IDLE next cycle. Then h_req and c_req together -> host wins (last=C).

Source files
------------

// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_arb_pkg : shared encodings for the data-memory port arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
package dmem_arb_pkg;

  typedef logic [1:0] arb_state_t;

  // Owner output reuses the state encoding directly.
  localparam arb_state_t ST_IDLE  = 2'b00;
  localparam arb_state_t ST_GNT_C = 2'b01;
  localparam arb_state_t ST_GNT_H = 2'b10;

  localparam logic REQ_C = 1'b0;
  localparam logic REQ_H = 1'b1;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_arbiter_if : core/host request ports plus the shared memory port
// Rev 1.0
// ---------------------------------------------------------------------------
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic          c_ack;
  logic [DW-1:0] c_rdata;
  logic          c_stall;

  logic          h_req;
  logic          h_we;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wdata;
  logic          h_lock;
  logic          h_ack;
  logic [DW-1:0] h_rdata;

  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_we;
  logic [DW-1:0] m_rdata;
  logic [1:0]    owner;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    input  h_req, h_we, h_addr, h_wdata, h_lock,
    input  m_rdata,
    output c_ack, c_rdata, c_stall,
    output h_ack, h_rdata,
    output m_addr, m_wdata, m_we, owner
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    output h_req, h_we, h_addr, h_wdata, h_lock,
    output m_rdata,
    input  c_ack, c_rdata, c_stall,
    input  h_ack, h_rdata,
    input  m_addr, m_wdata, m_we, owner
  );
endinterface
`default_nettype wire

// File: rtl/arb_burst_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// arb_burst_counter : saturating beat counter for the current bus owner
// Rev 1.0
// ---------------------------------------------------------------------------
module arb_burst_counter #(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic limit_hit
);
  localparam logic [CNT_W:0] LIMIT = (CNT_W+1)'(MAX_BURST);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_ext;

  assign cnt_ext = {1'b0, cnt_q};

  // Includes the beat being acked this cycle, so the switch lands right after it.
  assign limit_hit = (cnt_ext + {{CNT_W{1'b0}}, inc}) >= LIMIT;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_ext < LIMIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_arbiter : round-robin core/host arbiter for the data memory port
// Rev 1.0
// ---------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  dmem_arbiter_if.slave        bus
);
  arb_state_t    state_q, state_d;
  logic          last_q, last_d;
  logic          own_c, own_h;
  logic          x_req, y_req, x_we;
  logic          lock_hold, limit_hit, cnt_clr;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  assign own_c     = (state_q == ST_GNT_C);
  assign own_h     = (state_q == ST_GNT_H);
  assign lock_hold = own_h & bus.h_lock;

  // x = current owner, y = the other requester; all zero while idle.
  always_comb begin
    x_req     = 1'b0;
    y_req     = 1'b0;
    x_we      = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (own_c) begin
      x_req     = bus.c_req;
      y_req     = bus.h_req;
      x_we      = bus.c_we;
      sel_addr  = bus.c_addr;
      sel_wdata = bus.c_wdata;
    end else if (own_h) begin
      x_req     = bus.h_req;
      y_req     = bus.c_req;
      x_we      = bus.h_we;
      sel_addr  = bus.h_addr;
      sel_wdata = bus.h_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.c_req && bus.h_req) begin
          state_d = (last_q == REQ_H) ? ST_GNT_C : ST_GNT_H;
        end else if (bus.c_req) begin
          state_d = ST_GNT_C;
        end else if (bus.h_req) begin
          state_d = ST_GNT_H;
        end
      end
      ST_GNT_C, ST_GNT_H: begin
        if (!x_req || (y_req && limit_hit && !lock_hold)) begin
          cnt_clr = 1'b1;
          last_d  = own_h ? REQ_H : REQ_C;
          if (y_req) begin
            state_d = own_c ? ST_GNT_H : ST_GNT_C;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= REQ_H;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  arb_burst_counter #(
    .MAX_BURST (MAX_BURST),
    .CNT_W     (CNT_W)
  ) u_burst_counter (
    .clk       (clk),
    .rst       (rst),
    .clr       (cnt_clr),
    .inc       (x_req),
    .limit_hit (limit_hit)
  );

  assign bus.c_ack   = own_c & bus.c_req;
  assign bus.h_ack   = own_h & bus.h_req;
  assign bus.c_rdata = bus.c_ack ? bus.m_rdata : '0;
  assign bus.h_rdata = bus.h_ack ? bus.m_rdata : '0;
  assign bus.c_stall = bus.c_req & ~bus.c_ack;
  assign bus.m_addr  = sel_addr;
  assign bus.m_wdata = sel_wdata;
  // Reset kills any write strobe in the same cycle.
  assign bus.m_we    = x_we & x_req & ~rst;
  assign bus.owner   = state_q;
endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dmem_arbiter : directed stimulus with a cycle-level reference model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;
  localparam int MAXB = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

  dmem_arbiter #(
    .AW(32), .DW(32), .MAX_BURST(MAXB), .CNT_W(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'hA0A0_0000 | i;
      ref_mem[i] = 32'hA0A0_0000 | i;
    end
  end

  assign bus.m_rdata = mem[bus.m_addr[7:0]];

  always @(posedge clk) begin
    if (bus.m_we) mem[bus.m_addr[7:0]] <= bus.m_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mo = 0 idle / 1 core / 2 host, beats = acks since grant.
  int mo = 0, beats = 0, mlast = 2;
  bit started = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        logic ec_ack, eh_ack, e_we;
        logic [31:0] e_addr, e_wdata;
        ec_ack  = (mo == 1) && bus.c_req;
        eh_ack  = (mo == 2) && bus.h_req;
        e_addr  = (mo == 1) ? bus.c_addr  : (mo == 2) ? bus.h_addr  : 32'h0;
        e_wdata = (mo == 1) ? bus.c_wdata : (mo == 2) ? bus.h_wdata : 32'h0;
        e_we    = (ec_ack && bus.c_we || eh_ack && bus.h_we) && !rst;
        chk("owner",   bus.owner,   mo);
        chk("c_ack",   bus.c_ack,   ec_ack);
        chk("h_ack",   bus.h_ack,   eh_ack);
        chk("c_stall", bus.c_stall, bus.c_req && !ec_ack);
        chk("m_we",    bus.m_we,    e_we);
        chk("m_addr",  bus.m_addr,  e_addr);
        chk("m_wdata", bus.m_wdata, e_wdata);
        chk("c_rdata", bus.c_rdata, ec_ack ? ref_mem[bus.c_addr[7:0]] : 32'h0);
        chk("h_rdata", bus.h_rdata, eh_ack ? ref_mem[bus.h_addr[7:0]] : 32'h0);
      end
      // Predict the effect of the coming edge from the inputs held this cycle.
      if (rst) begin
        mo = 0; beats = 0; mlast = 2; started = 1;
      end else if (mo == 0) begin
        if (bus.c_req && bus.h_req) mo = (mlast == 2) ? 1 : 2;
        else if (bus.c_req)         mo = 1;
        else if (bus.h_req)         mo = 2;
      end else begin
        logic mine, other;
        mine  = (mo == 1) ? bus.c_req : bus.h_req;
        other = (mo == 1) ? bus.h_req : bus.c_req;
        if (mine && mo == 1 && bus.c_we) ref_mem[bus.c_addr[7:0]] = bus.c_wdata;
        if (mine && mo == 2 && bus.h_we) ref_mem[bus.h_addr[7:0]] = bus.h_wdata;
        if (!mine) begin
          mlast = mo; mo = other ? 3 - mo : 0; beats = 0;
        end else begin
          beats++;
          if (other && beats >= MAXB && !(mo == 2 && bus.h_lock)) begin
            mlast = mo; mo = 3 - mo; beats = 0;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus.c_req = 0; bus.c_we = 0; bus.c_addr = '0; bus.c_wdata = '0;
    bus.h_req = 0; bus.h_we = 0; bus.h_addr = '0; bus.h_wdata = '0; bus.h_lock = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    clear_reqs();
    step();
    step();
    rst = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1;
    clear_reqs();
    step();
    @(negedge clk);
    chk("lit_rst_owner", bus.owner, 0);
    chk("lit_rst_m_we",  bus.m_we,  0);
    chk("lit_rst_acks",  {bus.c_ack, bus.h_ack}, 0);
    step();
    rst = 0;

    // Core alone reads 0x10
    bus.c_req = 1; bus.c_addr = 32'h10;
    @(negedge clk); chk("lit_t1_idle_ack", bus.c_ack, 0);
    step();
    @(negedge clk);
    chk("lit_t1_owner", bus.owner, 1);
    chk("lit_t1_rdata", bus.c_rdata, 32'hA0A0_0010);
    chk("lit_t1_h_ack", bus.h_ack, 0);
    step(); bus.c_req = 0; step();

    // Simultaneous requests after reset: core first, burst of 4, then host
    do_reset();
    bus.c_req = 1; bus.c_addr = 32'h11;
    bus.h_req = 1; bus.h_addr = 32'h12;
    n = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i < 6 && bus.c_ack) n++;
      if (i == 5) begin
        chk("lit_t2_h_ack", bus.h_ack, 1);
        chk("lit_t2_owner", bus.owner, 2);
      end
      step();
    end
    chk("lit_t2_core_beats", n, 4);
    clear_reqs(); step(); step();

    // Host locked: core stalls throughout
    do_reset();
    bus.h_req = 1; bus.h_lock = 1; bus.h_addr = 32'h13;
    step();
    bus.c_req = 1; bus.c_addr = 32'h15;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.c_stall && bus.h_ack) n++;
      step();
    end
    chk("lit_t3_stall_cycles", n, 10);
    bus.h_lock = 0; bus.h_req = 0;
    step();
    @(negedge clk);
    chk("lit_t3_owner", bus.owner, 1);
    chk("lit_t3_c_ack", bus.c_ack, 1);
    step(); bus.c_req = 0; step();

    // Host write then read-back
    do_reset();
    bus.h_req = 1; bus.h_we = 1; bus.h_addr = 32'h20; bus.h_wdata = 32'hDEADBEEF;
    step();
    @(negedge clk); chk("lit_t4_we_write", bus.m_we, 1);
    step();
    bus.h_we = 0;
    @(negedge clk);
    chk("lit_t4_rdata", bus.h_rdata, 32'hDEADBEEF);
    chk("lit_t4_we_read", bus.m_we, 0);
    step(); bus.h_req = 0; step();

    // Reset during a core write burst drops the write
    do_reset();
    bus.c_req = 1; bus.c_we = 1; bus.c_addr = 32'h31; bus.c_wdata = 32'h0000_0001;
    step();
    @(negedge clk); chk("lit_t5_first_we", bus.m_we, 1);
    step();
    rst = 1; bus.c_addr = 32'h30; bus.c_wdata = 32'h5555_5555;
    @(negedge clk); chk("lit_t5_rst_we", bus.m_we, 0);
    step();
    rst = 0; clear_reqs();
    @(negedge clk);
    chk("lit_t5_owner", bus.owner, 0);
    chk("lit_t5_acks", {bus.c_ack, bus.h_ack}, 0);
    chk("lit_t5_mem30", mem[8'h30], 32'hA0A0_0030);
    chk("lit_t5_mem31", mem[8'h31], 32'h0000_0001);
    step();

    // Core withdraws to idle, then a tie goes to the host
    do_reset();
    bus.c_req = 1; bus.c_addr = 32'h14;
    step(); step();
    bus.c_req = 0;
    step();
    bus.c_req = 1; bus.h_req = 1; bus.h_addr = 32'h16;
    @(negedge clk); chk("lit_t6_idle", bus.owner, 0);
    step();
    @(negedge clk);
    chk("lit_t6_owner", bus.owner, 2);
    chk("lit_t6_h_ack", bus.h_ack, 1);
    chk("lit_t6_stall", bus.c_stall, 1);
    step();
    clear_reqs(); step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
